// File: rtl/counter_response_checker.sv
// Shadow-model checker for a binary counter: tracks the expected count, compares it against
// the DUT output every cycle, and keeps sticky pass/fail, error and sample statistics.
module counter_response_checker #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned ERRW   = 16,
    parameter bit          RESYNC = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] count_in,
    output logic             checking,
    output logic             mismatch,
    output logic             fail,
    output logic [ERRW-1:0]  err_count,
    output logic [31:0]      samples,
    output logic [WIDTH-1:0] first_got,
    output logic [WIDTH-1:0] first_exp
);

    typedef enum logic [1:0] {StIdle, StSync, StCheck} state_t;

    state_t           state;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] dut_next;
    logic [WIDTH-1:0] exp_next;

    assign dut_next = count_in + WIDTH'(inc);
    assign exp_next = exp + WIDTH'(inc);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            exp       <= '0;
            checking  <= 1'b0;
            mismatch  <= 1'b0;
            fail      <= 1'b0;
            err_count <= '0;
            samples   <= '0;
            first_got <= '0;
            first_exp <= '0;
        end else begin
            mismatch <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (enable) begin
                        state <= StSync;
                    end
                end
                StSync: begin
                    exp      <= dut_next;
                    checking <= enable;
                    state    <= enable ? StCheck : StIdle;
                end
                StCheck: begin
                    samples <= samples + 32'd1;
                    if (count_in == exp) begin
                        exp <= exp_next;
                    end else begin
                        mismatch <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + ERRW'(1);
                        end
                        if (!fail) begin
                            fail      <= 1'b1;
                            first_got <= count_in;
                            first_exp <= exp;
                        end
                        exp <= RESYNC ? dut_next : exp_next;
                    end
                    // The compare above still counts on the exit cycle.
                    if (!enable) begin
                        checking <= 1'b0;
                        state    <= StIdle;
                    end
                end
                default: begin
                    checking <= 1'b0;
                    state    <= StIdle;
                end
            endcase
            // Clear overrides any statistics update from this cycle's compare.
            if (clear) begin
                fail      <= 1'b0;
                err_count <= '0;
                samples   <= '0;
                first_got <= '0;
                first_exp <= '0;
            end
        end
    end

endmodule

// File: tb/tb_counter_response_checker.sv
// Directed bench: three checker instances (default, free-running model, narrow error counter)
// share one stimulus stream and are checked against hand-computed values.
module tb_counter_response_checker;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic       inc;
    logic [5:0] count_in;

    logic        c0_checking, c0_mismatch, c0_fail;
    logic [15:0] c0_err;
    logic [31:0] c0_samples;
    logic [5:0]  c0_got, c0_exp;

    logic        c1_checking, c1_mismatch, c1_fail;
    logic [15:0] c1_err;
    logic [31:0] c1_samples;
    logic [5:0]  c1_got, c1_exp;

    logic        c2_checking, c2_mismatch, c2_fail;
    logic [3:0]  c2_err;
    logic [31:0] c2_samples;
    logic [5:0]  c2_got, c2_exp;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    counter_response_checker #(.WIDTH(6), .ERRW(16), .RESYNC(1'b1)) u0 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .inc(inc),
        .count_in(count_in), .checking(c0_checking), .mismatch(c0_mismatch), .fail(c0_fail),
        .err_count(c0_err), .samples(c0_samples), .first_got(c0_got), .first_exp(c0_exp)
    );

    counter_response_checker #(.WIDTH(6), .ERRW(16), .RESYNC(1'b0)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .inc(inc),
        .count_in(count_in), .checking(c1_checking), .mismatch(c1_mismatch), .fail(c1_fail),
        .err_count(c1_err), .samples(c1_samples), .first_got(c1_got), .first_exp(c1_exp)
    );

    counter_response_checker #(.WIDTH(6), .ERRW(4), .RESYNC(1'b1)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .inc(inc),
        .count_in(count_in), .checking(c2_checking), .mismatch(c2_mismatch), .fail(c2_fail),
        .err_count(c2_err), .samples(c2_samples), .first_got(c2_got), .first_exp(c2_exp)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; inc = 1'b0; count_in = 6'd0;
        tick();
        tick();
        chk("rst_checking", 32'(c0_checking), 32'd0);
        chk("rst_mismatch", 32'(c0_mismatch), 32'd0);
        chk("rst_fail", 32'(c0_fail), 32'd0);
        chk("rst_err", 32'(c0_err), 32'd0);
        chk("rst_samples", c0_samples, 32'd0);
        chk("rst_first_got", 32'(c0_got), 32'd0);
        chk("rst_first_exp", 32'(c0_exp), 32'd0);

        // Correct counter, 0..63 then wrap: edge 0 idle, edge 1 sync, edges 2..100 compare.
        reset = 1'b0; enable = 1'b1; inc = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            count_in = 6'(i);
            tick();
        end
        chk("ok_fail", 32'(c0_fail), 32'd0);
        chk("ok_err", 32'(c0_err), 32'd0);
        chk("ok_samples", c0_samples, 32'd99);
        chk("ok_checking", 32'(c0_checking), 32'd1);
        chk("ok_fail_norsync", 32'(c1_fail), 32'd0);
        chk("ok_err_narrow", 32'(c2_err), 32'd0);

        // Leave CHECK with clear: the exit compare (37) passes, statistics zeroed.
        enable = 1'b0; clear = 1'b1; count_in = 6'd37;
        tick();
        chk("exit_checking", 32'(c0_checking), 32'd0);
        chk("exit_clear_samples", c0_samples, 32'd0);

        // Re-enter: sync on 11 gives model 12, DUT then glitches to 20.
        clear = 1'b0; enable = 1'b1; count_in = 6'd10;
        tick();
        chk("sync_checking", 32'(c0_checking), 32'd0);
        count_in = 6'd11;
        tick();
        chk("reenter_checking", 32'(c0_checking), 32'd1);
        count_in = 6'd20;
        tick();
        chk("glitch_mismatch", 32'(c0_mismatch), 32'd1);
        chk("glitch_fail", 32'(c0_fail), 32'd1);
        chk("glitch_got", 32'(c0_got), 32'd20);
        chk("glitch_exp", 32'(c0_exp), 32'd12);
        chk("glitch_err", 32'(c0_err), 32'd1);
        chk("glitch_samples", c0_samples, 32'd1);
        count_in = 6'd21;
        tick();
        chk("resync_pulse_end", 32'(c0_mismatch), 32'd0);
        chk("norsync_pulse", 32'(c1_mismatch), 32'd1);
        for (int v = 22; v <= 24; v++) begin
            count_in = 6'(v);
            tick();
        end
        chk("resync_err", 32'(c0_err), 32'd1);
        chk("resync_samples", c0_samples, 32'd5);
        chk("norsync_err", 32'(c1_err), 32'd5);
        chk("norsync_got", 32'(c1_got), 32'd20);
        chk("norsync_exp", 32'(c1_exp), 32'd12);

        // Hold with inc = 0, then a spurious increment.
        inc = 1'b0; count_in = 6'd25;
        for (int k = 0; k < 3; k++) tick();
        chk("hold_err", 32'(c0_err), 32'd1);
        chk("hold_mismatch", 32'(c0_mismatch), 32'd0);
        chk("hold_samples", c0_samples, 32'd8);
        count_in = 6'd26;
        tick();
        chk("spurious_mismatch", 32'(c0_mismatch), 32'd1);
        chk("spurious_err", 32'(c0_err), 32'd2);
        chk("spurious_got", 32'(c0_got), 32'd20);

        // Saturation: clear on a passing compare, then 20 failing compares.
        clear = 1'b1;
        tick();
        chk("clr_err_narrow", 32'(c2_err), 32'd0);
        chk("clr_fail_narrow", 32'(c2_fail), 32'd0);
        clear = 1'b0; inc = 1'b1; count_in = 6'd0;
        for (int k = 0; k < 20; k++) tick();
        chk("sat_err_narrow", 32'(c2_err), 32'd15);
        chk("sat_err_wide", 32'(c0_err), 32'd20);
        chk("sat_samples", c2_samples, 32'd20);
        chk("sat_got", 32'(c2_got), 32'd0);
        chk("sat_exp", 32'(c2_exp), 32'd26);
        clear = 1'b1;
        tick();
        chk("clrhit_mismatch", 32'(c2_mismatch), 32'd1);
        chk("clrhit_err", 32'(c2_err), 32'd0);
        chk("clrhit_fail", 32'(c2_fail), 32'd0);
        chk("clrhit_samples", c2_samples, 32'd0);
        chk("clrhit_exp", 32'(c2_exp), 32'd0);
        clear = 1'b0; count_in = 6'd1;
        tick();
        chk("postclr_mismatch", 32'(c2_mismatch), 32'd0);
        chk("postclr_samples", c2_samples, 32'd1);

        // Reset together with a failing compare and enable: reset wins, pulse dropped.
        reset = 1'b1; count_in = 6'd9;
        tick();
        chk("midrst_checking", 32'(c0_checking), 32'd0);
        chk("midrst_mismatch", 32'(c0_mismatch), 32'd0);
        chk("midrst_mismatch_norsync", 32'(c1_mismatch), 32'd0);
        chk("midrst_err", 32'(c1_err), 32'd0);
        chk("midrst_fail", 32'(c0_fail), 32'd0);
        chk("midrst_samples", c0_samples, 32'd0);

        reset = 1'b0; inc = 1'b0; count_in = 6'd40;
        tick();
        chk("re_idle_checking", 32'(c0_checking), 32'd0);
        inc = 1'b1;
        tick();
        chk("re_sync_checking", 32'(c0_checking), 32'd1);
        count_in = 6'd41;
        tick();
        chk("re_first_mismatch", 32'(c1_mismatch), 32'd0);
        chk("re_first_samples", c1_samples, 32'd1);
        count_in = 6'd50;
        tick();
        chk("re_bad_mismatch", 32'(c1_mismatch), 32'd1);
        chk("re_bad_got", 32'(c1_got), 32'd50);
        chk("re_bad_exp", 32'(c1_exp), 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
